// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the character-ROM scoreboard: converter FSM state
// encoding and the ASCII constants used to build each score row.
// -----------------------------------------------------------------------------
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [6:0] CHAR_ZERO  = 7'h30;
  localparam logic [6:0] CHAR_ONE   = 7'h31;
  localparam logic [6:0] CHAR_COLON = 7'h3A;

  // Row label "score" occupies columns 0..4.
  localparam int LABEL_LEN = 5;
  localparam logic [6:0] CHAR_S = 7'h73;
  localparam logic [6:0] CHAR_C = 7'h63;
  localparam logic [6:0] CHAR_O = 7'h6F;
  localparam logic [6:0] CHAR_R = 7'h72;
  localparam logic [6:0] CHAR_E = 7'h65;

  function automatic logic [6:0] label_char(input int idx);
    case (idx)
      0:       return CHAR_S;
      1:       return CHAR_C;
      2:       return CHAR_O;
      3:       return CHAR_R;
      4:       return CHAR_E;
      default: return CHAR_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd
// Iterative double-dabble converter, one bit per step.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : load value, clear BCD accumulator and overflow flag
//   step     : perform one add-3/shift iteration
//   value    : binary input, sampled on start
//   bcd      : DIGITS packed BCD digits, most significant digit in the top nibble
//   overflow : value did not fit in DIGITS decimal digits
// After SCORE_W steps bcd holds value mod 10**DIGITS and overflow is valid.
// -----------------------------------------------------------------------------
module bin2bcd #(
  parameter int SCORE_W = 16,
  parameter int DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [SCORE_W-1:0]    value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  logic [SCORE_W-1:0]  bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic                ovf_q;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // Digits only carry upward, so truncating to DIGITS keeps the lower digits
  // exact; any 1 shifted out of the top digit means the value overflowed.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      bin_q <= value;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (step) begin
      bin_q <= bin_q << 1;
      bcd_q <= {bcd_adj[4*DIGITS-2:0], bin_q[SCORE_W-1]};
      ovf_q <= ovf_q | bcd_adj[4*DIGITS-1];
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/char_rom_scoreboard.sv
// -----------------------------------------------------------------------------
// char_rom_scoreboard
// Character-cell source for a text-mode scoreboard. Each row r < NUM_PLAYERS
// reads "score<r+1>: " followed by DIGITS decimal digits; all other cells are
// spaces. Score updates are converted to BCD by an iterative double-dabble
// engine and committed atomically to the per-row digit registers.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   char_xy      : cell address, [11:8] row, [7:0] column
//   char_code    : ASCII code of the cell addressed one cycle earlier
//   score_valid  : update request
//   score_player : target row of the update
//   score_value  : new binary score
//   score_ready  : converter idle; request accepted this cycle if valid
// -----------------------------------------------------------------------------
module char_rom_scoreboard
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 5,
  parameter int SCORE_W     = 16,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        char_xy,
  output logic [6:0]         char_code,
  input  logic               score_valid,
  input  logic [1:0]         score_player,
  input  logic [SCORE_W-1:0] score_value,
  output logic               score_ready
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  state_t              state;
  logic [CNT_W-1:0]    step_cnt;
  logic [1:0]          player_q;
  logic                accept;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_ovf;
  logic [4*DIGITS-1:0] rows [NUM_PLAYERS];

  assign accept = score_valid && score_ready;

  bin2bcd #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .step     (state == SHIFT),
    .value    (score_value),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Converter FSM. score_ready is registered alongside the state so it is
  // high exactly while the FSM sits in IDLE.
  // NOTE: the digit rows are a handful of flops, not RAM, so they are cleared
  // by reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      score_ready <= 1'b1;
      step_cnt    <= '0;
      player_q    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) rows[p] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (score_valid) begin
            state       <= SHIFT;
            score_ready <= 1'b0;
            step_cnt    <= '0;
            player_q    <= score_player;
          end
        end
        SHIFT: begin
          if (step_cnt == CNT_W'(SCORE_W - 1)) state <= COMMIT;
          else step_cnt <= step_cnt + 1'b1;
        end
        COMMIT: begin
          // Out-of-range players match no row and are silently dropped.
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (player_q == 2'(p)) rows[p] <= conv_ovf ? {DIGITS{4'h9}} : conv_bcd;
          end
          state       <= IDLE;
          score_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          score_ready <= 1'b1;
        end
      endcase
    end
  end

  // Cell lookup.
  logic [3:0]          row;
  logic [7:0]          col;
  logic [4*DIGITS-1:0] sel_bcd;
  logic [3:0]          digit;
  logic                zero_run;
  logic [6:0]          next_char;

  assign row = char_xy[11:8];
  assign col = char_xy[7:0];

  always_comb begin
    sel_bcd   = '0;
    digit     = '0;
    zero_run  = 1'b1;
    next_char = CHAR_SPACE;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (row == 4'(p)) sel_bcd = rows[p];
    end
    if (row < 4'(NUM_PLAYERS)) begin
      for (int c = 0; c < LABEL_LEN; c++) begin
        if (col == 8'(c)) next_char = label_char(c);
      end
      if (col == 8'd5) next_char = CHAR_ONE + 7'(row);
      if (col == 8'd6) next_char = CHAR_COLON;
      // zero_run stays set while every digit so far, MSD first, is zero.
      for (int k = 0; k < DIGITS; k++) begin
        digit    = sel_bcd[4*(DIGITS-1-k) +: 4];
        zero_run = zero_run && (digit == 4'd0);
        if (col == 8'(8 + k)) begin
          if (BLANK_LZ != 0 && zero_run && k != DIGITS - 1) next_char = CHAR_SPACE;
          else next_char = CHAR_ZERO + 7'(digit);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) char_code <= CHAR_SPACE;
    else     char_code <= next_char;
  end

endmodule

// File: tb/tb_char_rom_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_char_rom_scoreboard
// Directed bench for char_rom_scoreboard. Three instances share one stimulus:
// defaults, DIGITS=4 (saturation), and BLANK_LZ=0 (leading zeros shown).
// -----------------------------------------------------------------------------
module tb_char_rom_scoreboard;

  localparam int SCORE_W = 16;

  logic        clk;
  logic        rst;
  logic [11:0] char_xy;
  logic        score_valid;
  logic [1:0]  score_player;
  logic [15:0] score_value;
  logic [6:0]  code_a, code_4, code_nb;
  logic        ready_a, ready_4, ready_nb;

  int checks = 0;
  int errors = 0;

  char_rom_scoreboard dut (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(code_a),
    .score_valid(score_valid), .score_player(score_player),
    .score_value(score_value), .score_ready(ready_a)
  );

  char_rom_scoreboard #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(code_4),
    .score_valid(score_valid), .score_player(score_player),
    .score_value(score_value), .score_ready(ready_4)
  );

  char_rom_scoreboard #(.BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(code_nb),
    .score_valid(score_valid), .score_player(score_player),
    .score_value(score_value), .score_ready(ready_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reads len cells starting at (r, c0) and compares all three instances.
  task automatic read_str(input string tag, input int r, input int c0,
                          input string e_a, input string e_4, input string e_nb);
    for (int i = 0; i < e_a.len(); i++) begin
      char_xy = {4'(r), 8'(c0 + i)};
      tick();
      check($sformatf("%s a col%0d", tag, c0 + i), 32'(code_a), 32'(e_a[i]));
      check($sformatf("%s d4 col%0d", tag, c0 + i), 32'(code_4), 32'(e_4[i]));
      check($sformatf("%s nb col%0d", tag, c0 + i), 32'(code_nb), 32'(e_nb[i]));
    end
  endtask

  // Counts cycles with score_ready low; bounded so a stuck FSM still ends.
  task automatic count_busy(output int lows);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready_a) break;
      lows++;
      tick();
    end
  endtask

  task automatic send(input logic [1:0] p, input logic [15:0] v, output int lows);
    score_valid  = 1'b1;
    score_player = p;
    score_value  = v;
    tick();
    score_valid = 1'b0;
    count_busy(lows);
  endtask

  int lows;

  initial begin
    rst          = 1'b1;
    char_xy      = {4'd0, 8'd3};
    score_valid  = 1'b0;
    score_player = '0;
    score_value  = '0;

    // Reset state
    tick();
    tick();
    check("reset code", 32'(code_a), 32'h20);
    check("reset ready", 32'(ready_a), 32'd1);
    rst = 1'b0;

    // Default display after reset
    read_str("reset row0", 0, 0, "score1:     0", "score1:    0 ", "score1: 00000");
    read_str("reset row1", 1, 0, "score2:     0", "score2:    0 ", "score2: 00000");

    // Player 1 <- 42; watch LSD of row 1 across the commit
    char_xy = {4'd1, 8'd12};
    send(2'd1, 16'd42, lows);
    check("busy 42", 32'(lows), 32'(SCORE_W + 1));
    check("ready4 42", 32'(ready_4), 32'd1);
    check("commit-cycle lookup old", 32'(code_a), 32'h30);
    tick();
    check("post-commit lookup new", 32'(code_a), 32'h32);
    read_str("row1 42", 1, 0, "score2:    42", "score2:   42 ", "score2: 00042");

    // Max value: fits 5 digits, saturates 4 digits
    send(2'd0, 16'd65535, lows);
    check("busy 65535", 32'(lows), 32'(SCORE_W + 1));
    read_str("row0 65535", 0, 8, "65535", "9999 ", "65535");

    // Valid held high with changing payload: second accepted only on ready
    score_valid  = 1'b1;
    score_player = 2'd0;
    score_value  = 16'd100;
    tick();
    score_player = 2'd1;
    score_value  = 16'd7;
    count_busy(lows);
    check("busy held", 32'(lows), 32'(SCORE_W + 1));
    tick();
    score_valid = 1'b0;
    check("second accept", 32'(ready_a), 32'd0);
    count_busy(lows);
    check("busy second", 32'(lows), 32'(SCORE_W + 1));
    read_str("row0 100", 0, 8, "  100", " 100 ", "00100");
    read_str("row1 7", 1, 8, "    7", "   7 ", "00007");

    // Reset mid-SHIFT aborts the conversion
    score_valid  = 1'b1;
    score_player = 2'd1;
    score_value  = 16'd999;
    tick();
    score_valid = 1'b0;
    repeat (5) tick();
    check("busy before reset", 32'(ready_a), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ready after reset", 32'(ready_a), 32'd1);
    check("code after reset", 32'(code_a), 32'h20);
    repeat (20) tick();
    check("ready stays idle", 32'(ready_a), 32'd1);
    read_str("row1 aborted", 1, 8, "    0", "   0 ", "00000");

    // Exactly 10**4: first value that saturates 4 digits
    send(2'd0, 16'd10000, lows);
    read_str("row0 10000", 0, 8, "10000", "9999 ", "10000");

    // Out-of-range player: converter still busy, no row touched
    send(2'd3, 16'd5, lows);
    check("busy discard", 32'(lows), 32'(SCORE_W + 1));
    read_str("row0 kept", 0, 8, "10000", "9999 ", "10000");
    read_str("row1 kept", 1, 8, "    0", "   0 ", "00000");

    // Cells outside the populated area
    read_str("row3 col200", 3, 200, " ", " ", " ");
    read_str("row2 col0", 2, 0, " ", " ", " ");
    read_str("row0 col13", 0, 13, " ", " ", " ");
    read_str("row0 col255", 0, 255, " ", " ", " ");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
